// File: rtl/ahb_split_ctrl.sv
// ahb_split_ctrl
//   SPLIT scheduler for one guarded slave on a 16-master AHB bus. When the
//   guarded resource is busy, it answers a transfer with a two-cycle SPLIT
//   response and queues the master. Queued masters are later released through
//   HSPLITx, one at a time and in FIFO order, once the resource is ready.
//
// Ports
//   HCLK, HRESETn           bus clock, async active-low reset
//   HSEL, HTRANS, HMASTER,  address-phase inputs
//   HMASTLOCK, HREADY
//   slv_ready_i             guarded resource can accept a transfer now
//   HREADYOUT, HRESP        slave response (OKAY or SPLIT)
//   HSPLITx                 one-hot release pulse to the arbiter
//   xfer_valid_o            pulse when an accepted transfer is forwarded
//   pending_o               bitmask of queued masters
//   q_full_o                queue holds QDEPTH entries
//
// FSM states
//   state     | meaning
//   ST_IDLE   | zero-wait OKAY, sampling address phases
//   ST_SPLIT1 | first SPLIT cycle (HREADYOUT=0); master enqueued at its end
//   ST_SPLIT2 | second SPLIT cycle (HREADYOUT=1)
//   ST_WAIT   | wait-stating a transfer that cannot be split
module ahb_split_ctrl #(
    parameter int QDEPTH     = 4,
    parameter int RELEASE_TO = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic [3:0]  HMASTER,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic        slv_ready_i,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [15:0] HSPLITx,
    output logic        xfer_valid_o,
    output logic [15:0] pending_o,
    output logic        q_full_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(RELEASE_TO + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SPLIT1, ST_SPLIT2, ST_WAIT} state_t;

    state_t        state;
    logic [3:0]    queue [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   pending, pending_nxt;
    logic [3:0]    cur_master, out_master, head;
    logic [TW-1:0] timer;
    logic          sample, q_full, rel_go, enq, can_split;
    logic          unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    assign sample = HSEL && HTRANS[1] && HREADY;
    assign q_full = (count == CW'(QDEPTH));
    assign head   = queue[rd_ptr];
    // A nonzero timer means a release is still outstanding.
    assign rel_go = slv_ready_i && (count != '0) && (timer == '0);

    // A master already pending is not queued twice, unless its only entry is
    // leaving the head this very cycle.
    assign enq = (state == ST_SPLIT1)
              && !(pending[cur_master] && !(rel_go && head == cur_master))
              && (!q_full || rel_go);

    assign can_split = !HMASTLOCK && (HMASTER != 4'd0)
                    && (!q_full || pending[HMASTER]);

    always_comb begin
        pending_nxt = pending;
        if (rel_go) pending_nxt[head] = 1'b0;
        if (enq)    pending_nxt[cur_master] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (enq) queue[wr_ptr] <= cur_master;
    end

    // Queue bookkeeping and release engine
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            HSPLITx    <= '0;
            out_master <= '0;
            timer      <= '0;
        end else begin
            pending <= pending_nxt;
            count   <= count + CW'(enq) - CW'(rel_go);
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (rel_go) begin
                HSPLITx    <= 16'(1) << head;
                rd_ptr     <= rd_ptr + PW'(1);
                out_master <= head;
                timer      <= TW'(RELEASE_TO);
            end else begin
                HSPLITx <= '0;
                if (timer != '0) begin
                    if (sample && HMASTER == out_master) timer <= '0;
                    else                                 timer <= timer - TW'(1);
                end
            end
        end
    end

    // Response FSM
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= ST_IDLE;
            HREADYOUT    <= 1'b1;
            HRESP        <= 2'b00;
            xfer_valid_o <= 1'b0;
            cur_master   <= '0;
        end else begin
            xfer_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b00;
                    if (sample) begin
                        cur_master <= HMASTER;
                        if (slv_ready_i) begin
                            xfer_valid_o <= 1'b1;
                        end else if (can_split) begin
                            state     <= ST_SPLIT1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 2'b11;
                        end else begin
                            state     <= ST_WAIT;
                            HREADYOUT <= 1'b0;
                        end
                    end
                end
                ST_SPLIT1: begin
                    state     <= ST_SPLIT2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b11;
                end
                ST_SPLIT2: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b00;
                end
                ST_WAIT: begin
                    if (slv_ready_i) begin
                        state        <= ST_IDLE;
                        HREADYOUT    <= 1'b1;
                        xfer_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 2'b00;
                end
            endcase
        end
    end

    assign pending_o = pending;
    assign q_full_o  = q_full;

endmodule

// File: tb/tb_ahb_split_ctrl.sv
module tb_ahb_split_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [1:0]  htrans;
    logic [3:0]  hmaster;
    logic        hmastlock;
    logic        hready;
    logic        slv_ready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [15:0] hsplit;
    logic        xfer_valid;
    logic [15:0] pending;
    logic        q_full;

    int n_checks = 0;
    int n_fail   = 0;

    // Single slave on the bus: its HREADYOUT is the bus HREADY.
    assign hready = hreadyout;

    always #5 clk = ~clk;

    ahb_split_ctrl #(.QDEPTH(4), .RELEASE_TO(16)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HTRANS(htrans),
        .HMASTER(hmaster), .HMASTLOCK(hmastlock), .HREADY(hready),
        .slv_ready_i(slv_ready), .HREADYOUT(hreadyout), .HRESP(hresp),
        .HSPLITx(hsplit), .xfer_valid_o(xfer_valid), .pending_o(pending),
        .q_full_o(q_full)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hmaster = 4'd0;
        hmastlock = 1'b0; slv_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Present one address phase; returns just after the sampling edge.
    task automatic addr(input logic [3:0] m, input logic lock);
        hsel = 1'b1; htrans = 2'b10; hmaster = m; hmastlock = lock;
        step();
        hsel = 1'b0; htrans = 2'b00; hmastlock = 1'b0;
    endtask

    task automatic split(input logic [3:0] m);
        addr(m, 1'b0);
        step(); step();
    endtask

    task automatic wait_pulse(output logic [15:0] val, output int cyc);
        val = '0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (hsplit != 16'h0) begin
                val = hsplit;
                cyc = i;
                break;
            end
        end
    endtask

    logic [15:0] pv;
    int          gap;

    initial begin
        // Reset state
        do_reset();
        chk("rst_rdy", {15'd0, hreadyout}, 16'h1);
        chk("rst_resp", {14'd0, hresp}, 16'h0);
        chk("rst_split", hsplit, 16'h0);
        chk("rst_pend", pending, 16'h0);
        chk("rst_xfer", {15'd0, xfer_valid}, 16'h0);

        // T1: reset in SPLIT1 with three queued
        split(4'd1); split(4'd2); split(4'd3);
        chk("t1_pend", pending, 16'h000E);
        addr(4'd4, 1'b0);
        chk("t1_split1_rdy", {15'd0, hreadyout}, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rdy", {15'd0, hreadyout}, 16'h1);
        chk("t1_resp", {14'd0, hresp}, 16'h0);
        chk("t1_pend0", pending, 16'h0);
        step();
        chk("t1_split", hsplit, 16'h0);
        chk("t1_full", {15'd0, q_full}, 16'h0);

        // T2: single split of master 5
        do_reset();
        addr(4'd5, 1'b0);
        chk("t2_s1_rdy", {15'd0, hreadyout}, 16'h0);
        chk("t2_s1_resp", {14'd0, hresp}, 16'h3);
        step();
        chk("t2_s2_rdy", {15'd0, hreadyout}, 16'h1);
        chk("t2_s2_resp", {14'd0, hresp}, 16'h3);
        chk("t2_pend", pending, 16'h0020);
        step();
        chk("t2_idle_resp", {14'd0, hresp}, 16'h0);

        // T3: FIFO release order 3, 7, 2
        do_reset();
        split(4'd3); split(4'd7); split(4'd2);
        chk("t3_pend", pending, 16'h008C);
        slv_ready = 1'b1;
        step();
        chk("t3_rel3", hsplit, 16'h0008);
        chk("t3_pend_after3", pending, 16'h0084);
        addr(4'd3, 1'b0);
        chk("t3_retry_xfer", {15'd0, xfer_valid}, 16'h1);
        chk("t3_retry_nosplit", hsplit, 16'h0);
        step();
        chk("t3_rel7", hsplit, 16'h0080);
        wait_pulse(pv, gap);
        chk("t3_rel2", pv, 16'h0004);
        chk("t3_gap", 16'(gap), 16'd17);
        chk("t3_pend_empty", pending, 16'h0);

        // T4: full queue forces wait states
        do_reset();
        split(4'd1); split(4'd2); split(4'd3); split(4'd4);
        chk("t4_full", {15'd0, q_full}, 16'h1);
        addr(4'd6, 1'b0);
        chk("t4_wait_rdy", {15'd0, hreadyout}, 16'h0);
        chk("t4_wait_resp", {14'd0, hresp}, 16'h0);
        step();
        chk("t4_wait_hold", {15'd0, hreadyout}, 16'h0);
        slv_ready = 1'b1;
        step();
        chk("t4_done_rdy", {15'd0, hreadyout}, 16'h1);
        chk("t4_xfer", {15'd0, xfer_valid}, 16'h1);
        chk("t4_pend", pending, 16'h001C);
        step();
        chk("t4_xfer_once", {15'd0, xfer_valid}, 16'h0);

        // T5: default master and locked transfers are wait-stated
        do_reset();
        addr(4'd0, 1'b0);
        chk("t5_m0_rdy", {15'd0, hreadyout}, 16'h0);
        chk("t5_m0_resp", {14'd0, hresp}, 16'h0);
        slv_ready = 1'b1;
        step();
        chk("t5_m0_xfer", {15'd0, xfer_valid}, 16'h1);
        slv_ready = 1'b0;
        step();
        addr(4'd9, 1'b1);
        chk("t5_lock_rdy", {15'd0, hreadyout}, 16'h0);
        chk("t5_lock_resp", {14'd0, hresp}, 16'h0);
        slv_ready = 1'b1;
        step();
        chk("t5_lock_xfer", {15'd0, xfer_valid}, 16'h1);
        chk("t5_pend", pending, 16'h0);

        // T6: release of head coincides with enqueue of master 8
        do_reset();
        split(4'd3); split(4'd4); split(4'd5);
        addr(4'd8, 1'b0);
        chk("t6_s1_rdy", {15'd0, hreadyout}, 16'h0);
        slv_ready = 1'b1;
        step();
        chk("t6_rel3", hsplit, 16'h0008);
        chk("t6_pend", pending, 16'h0130);
        chk("t6_full", {15'd0, q_full}, 16'h0);
        chk("t6_s2_resp", {14'd0, hresp}, 16'h3);
        wait_pulse(pv, gap);
        chk("t6_rel4", pv, 16'h0010);
        wait_pulse(pv, gap);
        chk("t6_rel5", pv, 16'h0020);
        wait_pulse(pv, gap);
        chk("t6_rel8", pv, 16'h0100);
        chk("t6_pend_empty", pending, 16'h0);
        wait_pulse(pv, gap);
        chk("t6_no_more", pv, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
